// File: rtl/inst_addr_gen_dual_pkg.sv
// Shared types and constants for the dual-way instruction address generator.
package inst_addr_gen_dual_pkg;

   localparam int          INST_W   = 32;
   localparam logic [31:0] PC_STEP  = 32'd8;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } state_e;

   // Jump targets always land on the even word of a pair.
   function automatic logic [INST_W-1:0] pair_align(input logic [INST_W-1:0] addr);
      return {addr[INST_W-1:3], 3'b000};
   endfunction

endpackage

// File: rtl/inst_addr_accept_track.sv
// Tracks which fetch way has already taken the current address pair,
// drives the per-way valids and flags when the whole pair has been accepted.
module inst_addr_accept_track (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_run,
   input  logic i_jump,
   input  logic i_jump_odd,
   input  logic i_ready0,
   input  logic i_ready1,
   output logic o_valid0,
   output logic o_valid1,
   output logic o_pair_done
);

   logic r_acc0;
   logic r_acc1;
   logic w_take0;
   logic w_take1;
   logic w_pair_done;

   assign o_valid0    = i_run & ~r_acc0;
   assign o_valid1    = i_run & ~r_acc1;
   assign w_take0     = o_valid0 & i_ready0;
   assign w_take1     = o_valid1 & i_ready1;
   assign w_pair_done = i_run & (r_acc0 | w_take0) & (r_acc1 | w_take1);
   assign o_pair_done = w_pair_done;

   // A redirect to the odd word pre-marks way0 as taken so only way1 issues.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc0 <= 1'b0;
         r_acc1 <= 1'b0;
      end else if (i_jump) begin
         r_acc0 <= i_jump_odd;
         r_acc1 <= 1'b0;
      end else if (w_pair_done) begin
         r_acc0 <= 1'b0;
         r_acc1 <= 1'b0;
      end else begin
         r_acc0 <= r_acc0 | w_take0;
         r_acc1 <= r_acc1 | w_take1;
      end
   end

endmodule

// File: rtl/inst_addr_gen_dual.sv
// PC generator feeding two fetch ways with PC / PC+4 per transfer.
// Optional performance counters are built when INST_ADDR_PERF_EN is defined.
module inst_addr_gen_dual #(
   parameter logic [31:0] RESET_PC = inst_addr_gen_dual_pkg::RESET_PC,
   parameter logic [31:0] PC_STEP  = inst_addr_gen_dual_pkg::PC_STEP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        jumpFlag_i,
   input  logic [31:0] jumpAddr_i,
   input  logic        ready_way0_i,
   input  logic        ready_way1_i,
   output logic        valid_way0_o,
   output logic        valid_way1_o,
   output logic [31:0] instAddr_way0_o,
   output logic [31:0] instAddr_way1_o,
   output logic        misalign_o
`ifdef INST_ADDR_PERF_EN
   ,
   output logic [31:0] pairCnt_o,
   output logic [31:0] stallCnt_o
`endif
);

   import inst_addr_gen_dual_pkg::*;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [INST_W-1:0] r_pc;
   logic              r_misalign;
   logic              w_run;
   logic              w_valid0;
   logic              w_valid1;
   logic              w_pair_done;

   assign w_run = (r_state == RUN);

   inst_addr_accept_track u_accept_track (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_run       (w_run),
      .i_jump      (jumpFlag_i),
      .i_jump_odd  (jumpAddr_i[2]),
      .i_ready0    (ready_way0_i),
      .i_ready1    (ready_way1_i),
      .o_valid0    (w_valid0),
      .o_valid1    (w_valid1),
      .o_pair_done (w_pair_done)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: a jump always wins and forces one bubble cycle.
   always_comb begin
      w_state_nxt = r_state;
      if (jumpFlag_i) begin
         w_state_nxt = REDIRECT;
      end else begin
         case (r_state)
            IDLE:     w_state_nxt = RUN;
            RUN:      w_state_nxt = RUN;
            REDIRECT: w_state_nxt = RUN;
            default:  w_state_nxt = IDLE;
         endcase
      end
   end

   // PC register; redirect overrides pair completion in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (jumpFlag_i) begin
         r_pc <= pair_align(jumpAddr_i);
      end else if (w_pair_done) begin
         r_pc <= r_pc + PC_STEP;
      end else begin
         r_pc <= r_pc;
      end
   end

   // Misalignment pulse; the low target bits are otherwise dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= jumpFlag_i & (jumpAddr_i[1:0] != 2'b00);
      end
   end

   assign valid_way0_o    = w_valid0;
   assign valid_way1_o    = w_valid1;
   assign instAddr_way0_o = r_pc;
   assign instAddr_way1_o = r_pc + 32'd4;
   assign misalign_o      = r_misalign;

`ifdef INST_ADDR_PERF_EN
   logic [31:0] r_pair_cnt;
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = w_run & (w_valid0 | w_valid1) & ~w_pair_done;

   // Saturating completed-pair and stall-cycle counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pair_cnt  <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (w_pair_done && (r_pair_cnt != 32'hFFFF_FFFF)) begin
            r_pair_cnt <= r_pair_cnt + 32'd1;
         end else begin
            r_pair_cnt <= r_pair_cnt;
         end
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
      end
   end

   assign pairCnt_o  = r_pair_cnt;
   assign stallCnt_o = r_stall_cnt;
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_inst_addr_gen_dual.sv
// Scoreboard bench: stimulus pushes the addresses each way must receive,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_inst_addr_gen_dual;

   logic        clk = 1'b0;
   logic        reset;
   logic        jumpFlag_i;
   logic [31:0] jumpAddr_i;
   logic        ready_way0_i;
   logic        ready_way1_i;
   logic        valid_way0_o;
   logic        valid_way1_o;
   logic [31:0] instAddr_way0_o;
   logic [31:0] instAddr_way1_o;
   logic        misalign_o;
`ifdef INST_ADDR_PERF_EN
   logic [31:0] pairCnt_o;
   logic [31:0] stallCnt_o;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp0[$];
   logic [31:0] exp1[$];

   inst_addr_gen_dual dut (
      .clk             (clk),
      .reset           (reset),
      .jumpFlag_i      (jumpFlag_i),
      .jumpAddr_i      (jumpAddr_i),
      .ready_way0_i    (ready_way0_i),
      .ready_way1_i    (ready_way1_i),
      .valid_way0_o    (valid_way0_o),
      .valid_way1_o    (valid_way1_o),
      .instAddr_way0_o (instAddr_way0_o),
      .instAddr_way1_o (instAddr_way1_o),
      .misalign_o      (misalign_o)
`ifdef INST_ADDR_PERF_EN
      ,
      .pairCnt_o       (pairCnt_o),
      .stallCnt_o      (stallCnt_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: each handshake seen at negedge happens at the next posedge.
   always @(negedge clk) begin
      if (!reset) begin
         if (valid_way0_o && ready_way0_i) begin
            if (exp0.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL way0_unexpected: got %h, required no handshake", instAddr_way0_o);
            end else begin
               chk("way0_addr", instAddr_way0_o, exp0.pop_front());
            end
         end
         if (valid_way1_o && ready_way1_i) begin
            if (exp1.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL way1_unexpected: got %h, required no handshake", instAddr_way1_o);
            end else begin
               chk("way1_addr", instAddr_way1_o, exp1.pop_front());
            end
         end
      end
   end

   initial begin
      reset        = 1'b1;
      jumpFlag_i   = 1'b0;
      jumpAddr_i   = 32'h0;
      ready_way0_i = 1'b0;
      ready_way1_i = 1'b0;
      repeat (3) step();
      chk("rst_valid0", {31'd0, valid_way0_o}, 32'd0);
      chk("rst_valid1", {31'd0, valid_way1_o}, 32'd0);
      chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
      chk("rst_addr0", instAddr_way0_o, 32'h8000_0000);
      chk("rst_addr1", instAddr_way1_o, 32'h8000_0004);

      // Streaming with both ways always ready.
      reset        = 1'b0;
      ready_way0_i = 1'b1;
      ready_way1_i = 1'b1;
      exp0.push_back(32'h8000_0000); exp1.push_back(32'h8000_0004);
      exp0.push_back(32'h8000_0008); exp1.push_back(32'h8000_000C);
      exp0.push_back(32'h8000_0010); exp1.push_back(32'h8000_0014);
      step();
      chk("first_valid0", {31'd0, valid_way0_o}, 32'd1);
      chk("first_valid1", {31'd0, valid_way1_o}, 32'd1);
      repeat (3) step();

      // Partial accept: way0 takes 8000_0018, way1 stalls three cycles.
      ready_way1_i = 1'b0;
      exp0.push_back(32'h8000_0018);
      step();
      chk("partial_valid0", {31'd0, valid_way0_o}, 32'd0);
      chk("partial_valid1", {31'd0, valid_way1_o}, 32'd1);
      chk("partial_pc_held", instAddr_way0_o, 32'h8000_0018);
      repeat (2) step();
      ready_way1_i = 1'b1;
      exp1.push_back(32'h8000_001C);
      step();
      ready_way0_i = 1'b0;
      ready_way1_i = 1'b0;
      chk("after_partial_addr0", instAddr_way0_o, 32'h8000_0020);
      chk("after_partial_valid0", {31'd0, valid_way0_o}, 32'd1);

      // Jump to odd word 8000_0104 while the current pair completes.
      ready_way0_i = 1'b1;
      ready_way1_i = 1'b1;
      jumpFlag_i   = 1'b1;
      jumpAddr_i   = 32'h8000_0104;
      exp0.push_back(32'h8000_0020); exp1.push_back(32'h8000_0024);
      step();
      jumpFlag_i = 1'b0;
      chk("bubble_valid0", {31'd0, valid_way0_o}, 32'd0);
      chk("bubble_valid1", {31'd0, valid_way1_o}, 32'd0);
      chk("odd_jump_misalign", {31'd0, misalign_o}, 32'd0);
      exp1.push_back(32'h8000_0104);
      exp0.push_back(32'h8000_0108); exp1.push_back(32'h8000_010C);
      step();
      chk("odd_valid0", {31'd0, valid_way0_o}, 32'd0);
      chk("odd_valid1", {31'd0, valid_way1_o}, 32'd1);
      chk("odd_addr1", instAddr_way1_o, 32'h8000_0104);
      repeat (2) step();
      ready_way0_i = 1'b0;
      ready_way1_i = 1'b0;

      // Jump coincident with pair completion at 8000_0110.
      ready_way0_i = 1'b1;
      ready_way1_i = 1'b1;
      jumpFlag_i   = 1'b1;
      jumpAddr_i   = 32'h8000_0200;
      exp0.push_back(32'h8000_0110); exp1.push_back(32'h8000_0114);
      step();
      jumpFlag_i   = 1'b0;
      ready_way0_i = 1'b0;
      ready_way1_i = 1'b0;
      chk("coincide_pc", instAddr_way0_o, 32'h8000_0200);
      chk("coincide_misalign", {31'd0, misalign_o}, 32'd0);
      step();
      chk("coincide_run_valid0", {31'd0, valid_way0_o}, 32'd1);

      // Misaligned target 8000_0202.
      jumpFlag_i = 1'b1;
      jumpAddr_i = 32'h8000_0202;
      step();
      jumpFlag_i = 1'b0;
      chk("misalign_pulse", {31'd0, misalign_o}, 32'd1);
      chk("misalign_addr", instAddr_way0_o, 32'h8000_0200);
      step();
      chk("misalign_clear", {31'd0, misalign_o}, 32'd0);

      // Wrap-around from FFFF_FFF8.
      jumpFlag_i = 1'b1;
      jumpAddr_i = 32'hFFFF_FFF8;
      step();
      jumpFlag_i   = 1'b0;
      ready_way0_i = 1'b1;
      ready_way1_i = 1'b1;
      exp0.push_back(32'hFFFF_FFF8); exp1.push_back(32'hFFFF_FFFC);
      exp0.push_back(32'h0000_0000); exp1.push_back(32'h0000_0004);
      step();
      chk("wrap_addr1", instAddr_way1_o, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr0", instAddr_way0_o, 32'h0000_0000);
      step();

      // Reset asserted mid-stall with acc0 set.
      ready_way1_i = 1'b0;
      exp0.push_back(32'h0000_0008);
      step();
      chk("stall_valid0", {31'd0, valid_way0_o}, 32'd0);
      ready_way0_i = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_valid0", {31'd0, valid_way0_o}, 32'd0);
      chk("midrst_valid1", {31'd0, valid_way1_o}, 32'd0);
      chk("midrst_pc", instAddr_way0_o, 32'h8000_0000);
`ifdef INST_ADDR_PERF_EN
      chk("midrst_pair_cnt", pairCnt_o, 32'd0);
      chk("midrst_stall_cnt", stallCnt_o, 32'd0);
`endif
      step();
      reset = 1'b0;
      step();
      chk("post_rst_valid0", {31'd0, valid_way0_o}, 32'd1);
      chk("post_rst_valid1", {31'd0, valid_way1_o}, 32'd1);
      chk("post_rst_addr0", instAddr_way0_o, 32'h8000_0000);

      repeat (2) step();
      chk("exp0_drained", exp0.size(), 32'd0);
      chk("exp1_drained", exp1.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
